prescaled_led_counter: RTL and testbench
========================================

# prescaled_led_counter

- Parametrised LED counter: a WIDTH-bit counter advanced by an N-bit clock prescaler, driving the board LEDs directly.
- Adds features the fixed 8-bit up-counter lacks:
  - up, down, bounce (ping-pong) and hold modes;
  - synchronous parallel load;
  - enable;
  - tick and terminal-count pulses for chaining or debug.
- Sits between the board clock pin and the LED pins, and can be cascaded through TC.

## Interface

Parameters:
- WIDTH, 8: counter and LED width; legal range ≥2.
- N, 22: prescaler width; legal range ≥1. One count per 2^N enabled cycles. Simulation benches use N=1.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RSTN  in  1  reset; asynchronous, active-low.
- EN  in  1  count enable. When low, both prescaler and counter freeze.
- MODE  in  2  00 up, 01 down, 10 bounce, 11 hold.
- LOAD  in  1  synchronous load of DIN.
- DIN  in  WIDTH  load value, binary.
- LEDS  out  WIDTH  registered counter value; encoding set by GRAY_OUT_EN.
- TICK  out  1  registered one-cycle pulse, coincident with each counter update slot.
- TC  out  1  registered one-cycle terminal-count pulse.

## Operation

- State: prescaler `pre[N-1:0]`, counter `cnt[WIDTH-1:0]`, direction `dir` (0 up, 1 down).
- Reset (RSTN=0, asynchronous):
  - pre=0, cnt=0, dir=0;
  - LEDS=0, TICK=0, TC=0.
- Internal tick is the combinational term `tick = EN & (pre == 2^N-1)`.
- Priority per edge, highest first:
  1. LOAD=1:
     - cnt=DIN, pre=0, TICK=0, TC=0;
     - dir is unchanged;
     - LOAD is honoured regardless of EN.
  2. EN=0: everything holds; TICK=0, TC=0.
  3. EN=1:
     - pre increments modulo 2^N;
     - TICK=tick;
     - on tick, cnt updates according to MODE (below).
- MODE 00 (up):
  - cnt+1 modulo 2^WIDTH; dir forced to 0.
  - TC=1 when cnt wraps 2^WIDTH-1 → 0.
- MODE 01 (down):
  - cnt-1 modulo 2^WIDTH; dir forced to 1.
  - TC=1 when cnt wraps 0 → 2^WIDTH-1.
- MODE 10 (bounce), moving in direction dir:
  - dir=0 and cnt=2^WIDTH-1: cnt becomes 2^WIDTH-2, dir becomes 1, TC=1.
  - dir=1 and cnt=0: cnt becomes 1, dir becomes 0, TC=1.
  - Endpoint values are therefore shown for exactly one count period.
- MODE 11 (hold): cnt and dir hold, TC=0. The prescaler keeps running and TICK still pulses.
- A MODE change takes effect at the next tick. Entering bounce keeps the current dir, so 00→10 continues upward.
- Without a tick, TC=0.

## Timing

- LEDS, TICK and TC are all registered. The LEDS change, TICK pulse and TC pulse appear in the same cycle.
- Count period is 2^N enabled cycles. With N=1 and EN held high: counter updates on the 2nd, 4th, 6th... rising edges after RSTN deasserts.
- Latency from tick to visible output is zero extra cycles: the update happens on the tick edge.
- LOAD → LEDS=DIN after one edge. The next count follows 2^N enabled edges after the load.
- Dropping EN mid-period preserves pre. The period resumes where it stopped, with no lost or extra counts.
- Asserting RSTN mid-period clears everything immediately, without waiting for CLK.

## Configuration

- GRAY_OUT_EN:
  - Defined: LEDS = cnt ^ (cnt >> 1), i.e. Gray code, from a register. Timing is identical, and TC/TICK are unchanged.
  - Undefined: LEDS = cnt, binary.
- DIN is always binary in both cases.

## Test plan

All scenarios use WIDTH=8, N=1.

- Reset then EN=1, MODE=00 → LEDS 0,1,2,3 on edges 2,4,6,8; TICK high on those cycles only.
- LOAD DIN=8'hFE, then count up → LEDS FE, FF, 00. TC=1 only in the cycle LEDS becomes 00.
- MODE=01 from 8'h01 → LEDS 00, FF. TC=1 in the FF cycle.
- MODE=10 loaded 8'hFE → FF, FE, FD. TC=1 in the FE cycle.
  - Then load 8'h01 with dir=1 → 00, 01. TC=1 in the 01 cycle.
- EN=0 for 5 cycles mid-period → LEDS, pre and TC frozen. After EN returns, the next update follows exactly the remaining prescaler cycles.
  - Additionally, RSTN=0 pulsed between edges → LEDS=0, TICK=0, TC=0 immediately.
- With GRAY_OUT_EN defined, counting 0..4 → LEDS 00, 01, 03, 02, 06.

Source files
------------

// File: rtl/prescaled_led_counter.sv
// rtl/prescaled_led_counter.sv - prescaled up/down/bounce/hold LED counter; optional Gray LEDS via GRAY_OUT_EN
module prescaled_led_counter #(
    parameter int WIDTH = 8,
    parameter int N     = 22
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             EN,
    input  logic [1:0]       MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] DIN,
    output logic [WIDTH-1:0] LEDS,
    output logic             TICK,
    output logic             TC
);

    localparam logic [N-1:0]     PRE_ONE = N'(1);
    localparam logic [N-1:0]     PRE_MAX = {N{1'b1}};
    localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] CNT_MIN = '0;

    localparam logic [1:0] MODE_UP     = 2'b00;
    localparam logic [1:0] MODE_DOWN   = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;

    logic [N-1:0]     pre_q, pre_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             dir_q, dir_d;
    logic [WIDTH-1:0] leds_q, leds_d;
    logic             tick_q, tick_d;
    logic             tc_q, tc_d;
    logic             tick;

    // Count slot: last prescaler state of an enabled period.
    assign tick = EN & (pre_q == PRE_MAX);

    // Next-state: load beats enable; counter only moves on a tick, per MODE.
    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        if (LOAD) begin
            cnt_d = DIN;
            pre_d = '0;
        end else if (EN) begin
            pre_d  = pre_q + PRE_ONE;
            tick_d = tick;
            if (tick) begin
                case (MODE)
                    MODE_UP: begin
                        cnt_d = cnt_q + CNT_ONE;
                        dir_d = 1'b0;
                        tc_d  = (cnt_q == CNT_MAX);
                    end
                    MODE_DOWN: begin
                        cnt_d = cnt_q - CNT_ONE;
                        dir_d = 1'b1;
                        tc_d  = (cnt_q == CNT_MIN);
                    end
                    MODE_BOUNCE: begin
                        if (!dir_q) begin
                            if (cnt_q == CNT_MAX) begin
                                cnt_d = cnt_q - CNT_ONE;
                                dir_d = 1'b1;
                                tc_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_q + CNT_ONE;
                            end
                        end else begin
                            if (cnt_q == CNT_MIN) begin
                                cnt_d = cnt_q + CNT_ONE;
                                dir_d = 1'b0;
                                tc_d  = 1'b1;
                            end else begin
                                cnt_d = cnt_q - CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        cnt_d = cnt_q;
                        dir_d = dir_q;
                    end
                endcase
            end
        end
    end

    // LED encoding is taken from the next counter value so LEDS lands on the same edge as cnt.
    always_comb begin
`ifdef GRAY_OUT_EN
        leds_d = cnt_d ^ (cnt_d >> 1);
`else
        leds_d = cnt_d;
`endif
    end

    // State and registered outputs; reset clears everything without waiting for CLK.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            dir_q  <= 1'b0;
            leds_q <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            dir_q  <= dir_d;
            leds_q <= leds_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
        end
    end

    assign LEDS = leds_q;
    assign TICK = tick_q;
    assign TC   = tc_q;

endmodule

// File: tb/tb_prescaled_led_counter.sv
// tb/tb_prescaled_led_counter.sv - directed self-checking bench for prescaled_led_counter (WIDTH=8, N=1)
module tb_prescaled_led_counter;

    logic       CLK;
    logic       RSTN;
    logic       EN;
    logic [1:0] MODE;
    logic       LOAD;
    logic [7:0] DIN;
    logic [7:0] LEDS;
    logic       TICK;
    logic       TC;

    int n_checks;
    int n_errors;
    logic [7:0] prev_cnt;

    prescaled_led_counter #(.WIDTH(8), .N(1)) dut (
        .CLK  (CLK),
        .RSTN (RSTN),
        .EN   (EN),
        .MODE (MODE),
        .LOAD (LOAD),
        .DIN  (DIN),
        .LEDS (LEDS),
        .TICK (TICK),
        .TC   (TC)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected LED pattern for a binary count value.
    function automatic logic [7:0] enc(input logic [7:0] b);
`ifdef GRAY_OUT_EN
        return b ^ (b >> 1);
`else
        return b;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One full count period (N=1): a quiet edge then the tick edge.
    task automatic period(input string tag, input logic [7:0] exp_cnt, input logic exp_tc);
        step();
        check({tag, "_mid_leds"}, LEDS, enc(prev_cnt));
        check({tag, "_mid_tick"}, TICK, 0);
        check({tag, "_mid_tc"}, TC, 0);
        step();
        check({tag, "_leds"}, LEDS, enc(exp_cnt));
        check({tag, "_tick"}, TICK, 1);
        check({tag, "_tc"}, TC, exp_tc);
        prev_cnt = exp_cnt;
    endtask

    task automatic load(input logic [7:0] v, input logic [1:0] m);
        LOAD = 1'b1;
        DIN  = v;
        MODE = m;
        step();
        check("load_leds", LEDS, enc(v));
        check("load_tick", TICK, 0);
        check("load_tc", TC, 0);
        LOAD = 1'b0;
        prev_cnt = v;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        RSTN = 1'b1;
        EN   = 1'b0;
        MODE = 2'b00;
        LOAD = 1'b0;
        DIN  = 8'h00;
        #2 RSTN = 1'b0;
        repeat (3) step();
        check("rst_leds", LEDS, 0);
        check("rst_tick", TICK, 0);
        check("rst_tc", TC, 0);
        RSTN = 1'b1;
        EN   = 1'b1;

        // Up count from reset: updates on edges 2,4,6,8.
        prev_cnt = 8'h00;
        for (int i = 1; i <= 4; i++) begin
            period("up", 8'(i), 1'b0);
        end

        // Up wrap.
        load(8'hFE, 2'b00);
        period("upw1", 8'hFF, 1'b0);
        period("upw2", 8'h00, 1'b1);

        // Down wrap.
        load(8'h01, 2'b01);
        period("dn1", 8'h00, 1'b0);
        period("dn2", 8'hFF, 1'b1);

        // One up count to set dir=0, then bounce at the top.
        MODE = 2'b00;
        period("pre_b", 8'h00, 1'b1);
        load(8'hFE, 2'b10);
        period("bu1", 8'hFF, 1'b0);
        period("bu2", 8'hFE, 1'b1);
        period("bu3", 8'hFD, 1'b0);

        // Bounce at the bottom with dir=1 kept across the load.
        load(8'h01, 2'b10);
        period("bd1", 8'h00, 1'b0);
        period("bd2", 8'h01, 1'b1);

        // Hold: count frozen but TICK still pulses.
        MODE = 2'b11;
        period("hold", 8'h01, 1'b0);

        // Enable drop mid-period.
        MODE = 2'b00;
        step();
        check("en_pre_leds", LEDS, enc(8'h01));
        check("en_pre_tick", TICK, 0);
        EN = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("en_off_leds", LEDS, enc(8'h01));
            check("en_off_tick", TICK, 0);
            check("en_off_tc", TC, 0);
        end
        EN = 1'b1;
        step();
        check("en_resume_leds", LEDS, enc(8'h02));
        check("en_resume_tick", TICK, 1);
        prev_cnt = 8'h02;
        period("en_next", 8'h03, 1'b0);

        // Asynchronous reset between edges.
        step();
        #3 RSTN = 1'b0;
        #1;
        check("arst_leds", LEDS, 0);
        check("arst_tick", TICK, 0);
        check("arst_tc", TC, 0);
        #2 RSTN = 1'b1;
        prev_cnt = 8'h00;
        period("post_rst", 8'h01, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
